updown_counter_core: RTL
========================

# updown_counter_core

Loadable, bounded up/down counter that responds to the driver-side stimulus on the counter interface (`rstn`, `load`, `up_down`, `data_in`) and produces `data_out` plus status pulses. It is the design-under-test end of the counter verification environment: the driver clocking block stimulates it, and the monitor clocking block samples its inputs and `data_out`. It adds configurable bounds, wrap or saturate behaviour, and a wrap-event counter for scoreboard cross-checks.

## Interface
- `WIDTH`, default 4: counter and data width; matches the 4-bit `data_in`/`data_out` of the interface.
- `MIN_VAL`, default 0: lower count bound, inclusive.
- `MAX_VAL`, default 11: upper count bound, inclusive. Legal only if `MIN_VAL < MAX_VAL <= 2**WIDTH-1`; elaboration-time assertion otherwise.
- `MODE`, default `CNT_WRAP`: `CNT_WRAP` or `CNT_SAT`.
- `WCNT_W`, default 8: width of the wrap-event counter.

- `clk` input 1: single clock; all state updates on posedge.
- `rstn` input 1: asynchronous active-low reset.
- `load` input 1: load `data_in` this cycle.
- `up_down` input 1: 1 = count up, 0 = count down. Ignored when `load` = 1.
- `data_in` input WIDTH: load value.
- `data_out` output WIDTH: registered count.
- `carry` output 1: one-cycle pulse when an up step crosses `MAX_VAL`.
- `borrow` output 1: one-cycle pulse when a down step crosses `MIN_VAL`.
- `load_err` output 1: one-cycle pulse when a load is rejected.
- `wrap_cnt` output WCNT_W: number of carry and borrow events since reset; saturates at all-ones.

## Operation
- While `rstn` = 0, asynchronously: `data_out` = `MIN_VAL`, `carry` = `borrow` = `load_err` = 0, `wrap_cnt` = 0.
- Every posedge with `rstn` = 1 performs exactly one action. Priority: load, then count. There is no idle or hold; the counter steps every cycle.
- **Load**, `load` = 1:
  - If `MIN_VAL <= data_in <= MAX_VAL`, then `data_out` <= `data_in`.
  - Otherwise `data_out` holds its value and `load_err` pulses.
  - A load never asserts `carry` or `borrow`.
- **Up**, `load` = 0 and `up_down` = 1:
  - If `data_out < MAX_VAL`, increment by 1.
  - At `MAX_VAL`, WRAP mode gives `MIN_VAL` with a `carry` pulse.
  - At `MAX_VAL`, SAT mode holds `MAX_VAL` with a `carry` pulse.
- **Down**, `load` = 0 and `up_down` = 0:
  - If `data_out > MIN_VAL`, decrement by 1.
  - At `MIN_VAL`, WRAP mode gives `MAX_VAL` with a `borrow` pulse.
  - At `MIN_VAL`, SAT mode holds `MIN_VAL` with a `borrow` pulse.
- In SAT mode, `carry`/`borrow` re-pulse on every cycle spent pushing against the bound.
- `wrap_cnt` increments by 1 on every cycle where `carry` or `borrow` is set (they are mutually exclusive). It holds at `2**WCNT_W-1`.
- Arithmetic: compute next value at WIDTH+1 bits, then compare to the bounds. No modular overflow may leak through; for example, with `MAX_VAL` = 15 and `WIDTH` = 4, an up step from 15 gives `MIN_VAL`, not a raw wrap.
- Direction changes take effect on the same edge they are sampled. There is no turnaround penalty.

## Timing
- Inputs are sampled at posedge k. `data_out`, `carry`, `borrow`, `load_err` and `wrap_cnt` update at posedge k, so the monitor clocking block sees them at posedge k+1. Latency is 1 cycle.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Status pulses last exactly one cycle unless the condition repeats on the next edge.
- Reset asserted mid-count clears all outputs immediately, with no clock needed.
- On reset release, the first posedge with `rstn` = 1 performs a normal action from `MIN_VAL`.

## Structure
- `counter_pkg` holds:
  - `cnt_mode_e` (`CNT_WRAP`, `CNT_SAT`);
  - a `DEF_WIDTH` = 4 constant;
  - a `cnt_status_t` struct of `carry`/`borrow`/`load_err`.
- Sub-module `counter_next`: combinational. It takes the current value, `load`, `up_down` and `data_in`, and returns the next value plus status. It is parameterised identically to the top module.
- The top module holds only the registers and the `wrap_cnt` saturation logic.

## Test plan
- Reset, then `load`=1 with `data_in`=5, then 8 cycles up -> `data_out` 5,6,...,11,0,1. `carry` pulses on the 11->0 step; `wrap_cnt`=1.
- `data_out`=0, 3 cycles down, WRAP -> `data_out` 11,10,9. `borrow` pulses only on the 0->11 step.
- `load`=1 with `data_in`=13 while `data_out`=4 -> `data_out` stays 4, `load_err`=1 for one cycle, no `carry`/`borrow`.
- SAT mode, `data_out`=11, 3 cycles up -> `data_out` stays 11, `carry` high for 3 cycles, `wrap_cnt`=3. Then 1 cycle down -> 10.
- `load`=1 and `up_down`=1 together with `data_in`=11 -> `data_out`=11, no `carry`. Next cycle up -> 0 with `carry`.
- Assert `rstn`=0 asynchronously while counting at 7 with `wrap_cnt`=2 -> all outputs are 0 before the next posedge. After release, the first up step gives 1.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared types for the bounded up/down counter: mode selector, default width
// and the per-cycle status bundle.
package counter_pkg;

  typedef enum logic {
    CNT_WRAP = 1'b0,
    CNT_SAT  = 1'b1
  } cnt_mode_e;

  localparam int DEF_WIDTH = 4;

  typedef struct packed {
    logic carry;
    logic borrow;
    logic load_err;
  } cnt_status_t;

endpackage

// File: rtl/counter_next.sv
// Combinational next-state for the bounded counter: picks load or step and
// flags bound crossings and rejected loads.
module counter_next
  import counter_pkg::*;
#(
  parameter int        WIDTH   = DEF_WIDTH,
  parameter int        MIN_VAL = 0,
  parameter int        MAX_VAL = 11,
  parameter cnt_mode_e MODE    = CNT_WRAP,
  parameter int        WCNT_W  = 8
) (
  input  logic [WIDTH-1:0] cur,
  input  logic             load,
  input  logic             up_down,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] nxt,
  output cnt_status_t      status
);

  if (WCNT_W < 1) begin : g_bad_wcnt
    $error("counter_next: WCNT_W must be at least 1");
  end

  // One spare bit above WIDTH keeps MAX+1 exact, one more gives a sign for MIN-1.
  localparam logic signed [WIDTH+1:0] MIN_S = (WIDTH+2)'(MIN_VAL);
  localparam logic signed [WIDTH+1:0] MAX_S = (WIDTH+2)'(MAX_VAL);
  localparam logic signed [WIDTH+1:0] ONE_S = (WIDTH+2)'(1);
  localparam logic [WIDTH-1:0]        MIN_U = WIDTH'(MIN_VAL);
  localparam logic [WIDTH-1:0]        MAX_U = WIDTH'(MAX_VAL);

  logic signed [WIDTH+1:0] cur_s;
  logic signed [WIDTH+1:0] din_s;
  logic signed [WIDTH+1:0] inc_s;
  logic signed [WIDTH+1:0] dec_s;

  always_comb begin
    cur_s  = $signed({2'b00, cur});
    din_s  = $signed({2'b00, data_in});
    inc_s  = cur_s + ONE_S;
    dec_s  = cur_s - ONE_S;
    nxt    = cur;
    status = '0;
    if (load) begin
      if (din_s >= MIN_S && din_s <= MAX_S) begin
        nxt = data_in;
      end else begin
        status.load_err = 1'b1;
      end
    end else if (up_down) begin
      if (inc_s <= MAX_S) begin
        nxt = inc_s[WIDTH-1:0];
      end else begin
        status.carry = 1'b1;
        nxt          = (MODE == CNT_SAT) ? MAX_U : MIN_U;
      end
    end else begin
      if (dec_s >= MIN_S) begin
        nxt = dec_s[WIDTH-1:0];
      end else begin
        status.borrow = 1'b1;
        nxt           = (MODE == CNT_SAT) ? MIN_U : MAX_U;
      end
    end
  end

endmodule

// File: rtl/updown_counter_core.sv
// Loadable bounded up/down counter with wrap or saturate mode, registered
// status pulses and a saturating count of carry/borrow events.
module updown_counter_core
  import counter_pkg::*;
#(
  parameter int        WIDTH   = DEF_WIDTH,
  parameter int        MIN_VAL = 0,
  parameter int        MAX_VAL = 11,
  parameter cnt_mode_e MODE    = CNT_WRAP,
  parameter int        WCNT_W  = 8
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              load,
  input  logic              up_down,
  input  logic [WIDTH-1:0]  data_in,
  output logic [WIDTH-1:0]  data_out,
  output logic              carry,
  output logic              borrow,
  output logic              load_err,
  output logic [WCNT_W-1:0] wrap_cnt
);

  if (!(MIN_VAL >= 0 && MIN_VAL < MAX_VAL && MAX_VAL <= (2**WIDTH) - 1)) begin : g_bad_bounds
    $error("updown_counter_core: need 0 <= MIN_VAL < MAX_VAL <= 2**WIDTH-1");
  end

  localparam logic [WCNT_W-1:0] WCNT_MAX = '1;

  logic [WIDTH-1:0] nxt_val;
  cnt_status_t      nxt_status;

  counter_next #(
    .WIDTH   (WIDTH),
    .MIN_VAL (MIN_VAL),
    .MAX_VAL (MAX_VAL),
    .MODE    (MODE),
    .WCNT_W  (WCNT_W)
  ) u_next (
    .cur     (data_out),
    .load    (load),
    .up_down (up_down),
    .data_in (data_in),
    .nxt     (nxt_val),
    .status  (nxt_status)
  );

  // Single register stage: every output is a flop, one cycle after sampling.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      data_out <= WIDTH'(MIN_VAL);
      carry    <= 1'b0;
      borrow   <= 1'b0;
      load_err <= 1'b0;
      wrap_cnt <= '0;
    end else begin
      data_out <= nxt_val;
      carry    <= nxt_status.carry;
      borrow   <= nxt_status.borrow;
      load_err <= nxt_status.load_err;
      if ((nxt_status.carry || nxt_status.borrow) && wrap_cnt != WCNT_MAX) begin
        wrap_cnt <= wrap_cnt + 1'b1;
      end
    end
  end

endmodule
